mix_output_stage: RTL and testbench
===================================

// Module: mix_output_stage
// PURPOSE
//  Consumes the 19-bit signed 8-voice mix sum and runs it through a pipeline: master attenuation, saturation to 16 bits, codec-word formatting.
//  Buffers samples in a small FIFO and drains them to the audio codec write port under its allowed/write handshake.
//  Also drives a held clip indicator and an overflow counter for debug LEDs/HEX.
// PARAMETERS
//  IN_W        19          width of signed mix input
//  FIFO_DEPTH  4           codec-side sample buffer entries (power of 2, >=2)
//  CLIP_HOLD   25000000    cycles clip_led stays lit after last clip (0.5 s @ 50 MHz)
// PORTS
//  CLOCK_50           in   1      system clock, all logic on rising edge
//  resetn             in   1      asynchronous active-low reset
//  mix_in             in   IN_W   signed mix sum (two's complement)
//  mix_valid          in   1      one-cycle strobe per sample period; mix_in valid on that cycle
//  gain_shift         in   2      master attenuation: arithmetic right shift 0..3
//  mute               in   1      force output samples to zero
//  audio_out_allowed  in   1      codec FIFO has space
//  write_audio_out    out  1      codec write strobe
//  left_audio_out     out  32     codec left word
//  right_audio_out    out  32     codec right word (identical to left, mono)
//  clip_led           out  1      saturation seen within last CLIP_HOLD cycles
//  overflow_cnt       out  8      samples dropped on FIFO full, saturates at 255
// BEHAVIOUR
//  Reset (async, resetn=0): all pipeline regs 0. Valid bits 0. FIFO empty. clip_led=0. overflow_cnt=0.
//   Outputs write_audio_out=0, left/right_audio_out=0. In-flight samples are discarded.
//  S1 (edge where mix_valid=1): register mix_in, gain_shift, mute; v1<=1, else v1<=0.
//  S2 (next edge): y = mix_in >>> gain_shift (sign-preserving).
//   sat16 = 32767 if y>32767; -32768 if y<-32768; else y[15:0]. clip pulse if either limit hit.
//   If mute, sat16=0 and no clip pulse. v2<=v1.
//  Push (next edge, v2=1): word {sat16,16'h0000} written to FIFO tail.
//   Latency mix_valid -> head visible: 3 edges.
//  Drain: write_audio_out = !empty && audio_out_allowed (combinational). left/right_audio_out = FIFO head.
//   When empty, both words are 0. Pop on every edge where write_audio_out=1.
//  Full: push when full and no pop -> sample dropped, overflow_cnt+1 (stick at 255).
//   Push+pop same edge when full -> both succeed, no drop. Push+pop when empty -> push only; pop suppressed.
//  mix_valid on consecutive cycles is legal; each is a distinct sample.
//  clip counter: loads CLIP_HOLD on clip pulse (reload wins over decrement), else decrements to 0.
//   clip_led = (counter!=0).
// CONFIGURATION
//  PEAK_METER_EN defined: extra output peak_level[15:0] = max |sat16| since last decay.
//   Decays by 1 LSB every 2^16 cycles. |-32768| reported as 32767. Reset value 0.
//  PEAK_METER_EN undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  Package mix_pkg: IN_W default, SAMPLE_W=16, CODEC_W=32, SAT_MAX=16'sd32767, SAT_MIN=-16'sd32768.
//  Sub-module mix_out_fifo: depth-parameterised sync FIFO with push/pop/full/empty and head data.
//   It has async active-low reset. Pipeline, saturation and clip logic stay in mix_output_stage.
// TESTING
//  1. gain_shift=0, mix_in=1000, allowed=1 -> 3 edges later write_audio_out=1, left=right=32'h03E8_0000.
//  2. mix_in=+100000, gain_shift=0 -> word 32'h7FFF_0000, clip_led=1 for CLIP_HOLD cycles, then 0.
//   mix_in=-100000 -> 32'h8000_0000.
//  3. mix_in=-80000, gain_shift=2 -> -20000 -> 32'hB1E0_0000, no clip. mute=1 -> 32'h0000_0000, no clip.
//  4. allowed=0, 6 strobes -> 4 buffered, overflow_cnt=2. Then allowed=1 -> 4 writes in order, then write_audio_out=0.
//  5. FIFO full, allowed=1 and push same edge -> no drop, overflow_cnt unchanged, order preserved.
//  6. resetn low mid-stream with FIFO 3 full -> outputs 0, empty, counters 0 immediately.
//   After release, first new sample appears after 3 edges.

Source files
------------

// File: rtl/mix_pkg.sv
// Shared widths, saturation limits and sample helpers for the mix output stage.
package mix_pkg;

    localparam int IN_W_DEFAULT = 19;
    localparam int SAMPLE_W     = 16;
    localparam int CODEC_W      = 32;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic        [CODEC_W-1:0]  codec_word_t;

    localparam sample_t SAT_MAX = 16'sd32767;
    localparam sample_t SAT_MIN = -16'sd32768;

    // Codec expects the sample left-justified in the 32-bit word.
    function automatic codec_word_t to_codec_word(input sample_t s);
        return {s, {(CODEC_W-SAMPLE_W){1'b0}}};
    endfunction

    // Magnitude with -32768 folded onto 32767 so it fits a 16-bit meter.
    function automatic logic [SAMPLE_W-1:0] sample_abs(input sample_t s);
        if (s == SAT_MIN) return SAT_MAX;
        if (s < 0)        return -s;
        return s;
    endfunction

endpackage

// File: rtl/mix_out_fifo.sv
// Small synchronous FIFO between the sample pipeline and the codec write port.
module mix_out_fifo
    import mix_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CODEC_W
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the slot the simultaneous push needs, so a full FIFO still accepts.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
        else if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mix_output_stage.sv
// Mix sum -> attenuate -> saturate -> codec FIFO, with clip LED and drop counter.
// Optional peak meter output enabled by defining PEAK_METER_EN.
module mix_output_stage
    import mix_pkg::*;
#(
    parameter int IN_W       = IN_W_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int CLIP_HOLD  = 25000000
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic signed [IN_W-1:0] mix_in,
    input  logic                   mix_valid,
    input  logic [1:0]             gain_shift,
    input  logic                   mute,
    input  logic                   audio_out_allowed,
    output logic                   write_audio_out,
    output logic [CODEC_W-1:0]     left_audio_out,
    output logic [CODEC_W-1:0]     right_audio_out,
    output logic                   clip_led,
    output logic [7:0]             overflow_cnt
`ifdef PEAK_METER_EN
    ,
    output logic [SAMPLE_W-1:0]    peak_level
`endif
);

    localparam int CLIP_W = $clog2(CLIP_HOLD + 1);
    localparam logic signed [IN_W-1:0] SAT_MAX_EXT = IN_W'(SAT_MAX);
    localparam logic signed [IN_W-1:0] SAT_MIN_EXT = IN_W'(SAT_MIN);

    logic signed [IN_W-1:0] mix_q;
    logic [1:0]             gain_q;
    logic                   mute_q, v1_q;
    sample_t                sat_q;
    logic                   v2_q;
    logic [CLIP_W-1:0]      clip_cnt_q;
    logic [7:0]             ovf_q;

    logic signed [IN_W-1:0] y;
    sample_t                sat_d;
    logic                   clip_d;
    logic                   fifo_full, fifo_empty, drop;
    codec_word_t            fifo_head;

    always_comb begin
        y      = mix_q >>> gain_q;
        sat_d  = y[SAMPLE_W-1:0];
        clip_d = 1'b0;
        if (y > SAT_MAX_EXT) begin
            sat_d  = SAT_MAX;
            clip_d = 1'b1;
        end else if (y < SAT_MIN_EXT) begin
            sat_d  = SAT_MIN;
            clip_d = 1'b1;
        end
        if (mute_q) begin
            sat_d  = '0;
            clip_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            mix_q      <= '0;
            gain_q     <= '0;
            mute_q     <= 1'b0;
            v1_q       <= 1'b0;
            sat_q      <= '0;
            v2_q       <= 1'b0;
            clip_cnt_q <= '0;
            ovf_q      <= '0;
        end else begin
            v1_q <= mix_valid;
            if (mix_valid) begin
                mix_q  <= mix_in;
                gain_q <= gain_shift;
                mute_q <= mute;
            end
            v2_q <= v1_q;
            if (v1_q) sat_q <= sat_d;
            // A fresh clip restarts the hold even while the LED is already lit.
            if (v1_q && clip_d)       clip_cnt_q <= CLIP_W'(CLIP_HOLD);
            else if (clip_cnt_q != '0) clip_cnt_q <= clip_cnt_q - CLIP_W'(1);
            if (drop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
        end
    end

    assign write_audio_out = !fifo_empty && audio_out_allowed;
    assign drop            = v2_q && fifo_full && !write_audio_out;

    mix_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CODEC_W)
    ) u_fifo (
        .clk_i   (CLOCK_50),
        .rst_n_i (resetn),
        .push_i  (v2_q),
        .data_i  (to_codec_word(sat_q)),
        .pop_i   (write_audio_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign left_audio_out  = fifo_empty ? '0 : fifo_head;
    assign right_audio_out = left_audio_out;
    assign clip_led        = (clip_cnt_q != '0);
    assign overflow_cnt    = ovf_q;

`ifdef PEAK_METER_EN
    logic [15:0]         decay_q;
    logic [SAMPLE_W-1:0] peak_q, peak_d, new_abs;

    assign new_abs = sample_abs(sat_q);

    always_comb begin
        peak_d = peak_q;
        if (decay_q == 16'hFFFF && peak_q != '0) peak_d = peak_q - SAMPLE_W'(1);
        if (v2_q && new_abs > peak_d)            peak_d = new_abs;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            decay_q <= '0;
            peak_q  <= '0;
        end else begin
            decay_q <= decay_q + 16'd1;
            peak_q  <= peak_d;
        end
    end

    assign peak_level = peak_q;
`endif

endmodule

// File: tb/tb_mix_output_stage.sv
// Bench for mix_output_stage: vector table for the sample path plus hand sequences for FIFO and reset corners.
module tb_mix_output_stage;

    localparam int CLIP_HOLD = 20;

    logic               CLOCK_50;
    logic               resetn;
    logic signed [18:0] mix_in;
    logic               mix_valid;
    logic [1:0]         gain_shift;
    logic               mute;
    logic               audio_out_allowed;
    logic               write_audio_out;
    logic [31:0]        left_audio_out, right_audio_out;
    logic               clip_led;
    logic [7:0]         overflow_cnt;
`ifdef PEAK_METER_EN
    logic [15:0]        peak_level;
`endif

    mix_output_stage #(
        .IN_W       (19),
        .FIFO_DEPTH (4),
        .CLIP_HOLD  (CLIP_HOLD)
    ) dut (
        .CLOCK_50          (CLOCK_50),
        .resetn            (resetn),
        .mix_in            (mix_in),
        .mix_valid         (mix_valid),
        .gain_shift        (gain_shift),
        .mute              (mute),
        .audio_out_allowed (audio_out_allowed),
        .write_audio_out   (write_audio_out),
        .left_audio_out    (left_audio_out),
        .right_audio_out   (right_audio_out),
        .clip_led          (clip_led),
        .overflow_cnt      (overflow_cnt)
`ifdef PEAK_METER_EN
        ,
        .peak_level        (peak_level)
`endif
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: sample just before the rising edge that performs the pop.
    always begin
        @(negedge CLOCK_50);
        #4;
        if (resetn && write_audio_out) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got %h expected no write", left_audio_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("left_word", left_audio_out, mon_exp);
                check("right_word", right_audio_out, mon_exp);
            end
        end
    end

    typedef struct {
        logic signed [18:0] mix;
        logic [1:0]         gain;
        logic               mu;
        logic [31:0]        word;
        logic               clip;
    } vec_t;

    vec_t vecs[12];

    // Strobe one sample at the current negedge and check the 3-edge latency.
    task automatic latency_run(input logic signed [18:0] m, input logic [31:0] w);
        mix_in = m; gain_shift = 2'd0; mute = 1'b0; mix_valid = 1'b1;
        exp_q.push_back(w);
        @(negedge CLOCK_50);
        mix_valid = 1'b0;
        check("lat_edge1_write", {31'd0, write_audio_out}, 32'd0);
        @(negedge CLOCK_50);
        check("lat_edge2_write", {31'd0, write_audio_out}, 32'd0);
        @(negedge CLOCK_50);
        check("lat_edge3_write", {31'd0, write_audio_out}, 32'd1);
        check("lat_edge3_left", left_audio_out, w);
    endtask

    initial begin
        vecs[0]  = '{19'sd1000,    2'd0, 1'b0, 32'h03E8_0000, 1'b0};
        vecs[1]  = '{19'sd100000,  2'd0, 1'b0, 32'h7FFF_0000, 1'b1};
        vecs[2]  = '{-19'sd100000, 2'd0, 1'b0, 32'h8000_0000, 1'b1};
        vecs[3]  = '{-19'sd80000,  2'd2, 1'b0, 32'hB1E0_0000, 1'b0};
        vecs[4]  = '{-19'sd80000,  2'd2, 1'b1, 32'h0000_0000, 1'b0};
        vecs[5]  = '{19'sd100000,  2'd0, 1'b1, 32'h0000_0000, 1'b0};
        vecs[6]  = '{19'sd262143,  2'd2, 1'b0, 32'h7FFF_0000, 1'b1};
        vecs[7]  = '{-19'sd262144, 2'd1, 1'b0, 32'h8000_0000, 1'b1};
        vecs[8]  = '{-19'sd1001,   2'd1, 1'b0, 32'hFE0B_0000, 1'b0};
        vecs[9]  = '{-19'sd1,      2'd3, 1'b0, 32'hFFFF_0000, 1'b0};
        vecs[10] = '{19'sd32768,   2'd0, 1'b0, 32'h7FFF_0000, 1'b1};
        vecs[11] = '{-19'sd32769,  2'd0, 1'b0, 32'h8000_0000, 1'b1};

        resetn = 1'b0; mix_in = '0; mix_valid = 1'b0; gain_shift = '0;
        mute = 1'b0; audio_out_allowed = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        check("reset_write", {31'd0, write_audio_out}, 32'd0);
        check("reset_left", left_audio_out, 32'd0);
        check("reset_right", right_audio_out, 32'd0);
        check("reset_clip", {31'd0, clip_led}, 32'd0);
        check("reset_ovf", {24'd0, overflow_cnt}, 32'd0);
        resetn = 1'b1;
        @(negedge CLOCK_50);

        latency_run(19'sd1000, 32'h03E8_0000);
        repeat (3) @(negedge CLOCK_50);

        for (int i = 0; i < 12; i++) begin
            mix_in = vecs[i].mix; gain_shift = vecs[i].gain; mute = vecs[i].mu;
            mix_valid = 1'b1;
            exp_q.push_back(vecs[i].word);
            @(negedge CLOCK_50);
            mix_valid = 1'b0;
            repeat (2) @(negedge CLOCK_50);
            check("vec_write", {31'd0, write_audio_out}, 32'd1);
            check("vec_clip", {31'd0, clip_led}, {31'd0, vecs[i].clip});
            repeat (CLIP_HOLD + 4) @(negedge CLOCK_50);
            check("vec_clip_release", {31'd0, clip_led}, 32'd0);
        end
        mute = 1'b0; gain_shift = 2'd0;

        // Clip hold length: LED must stay lit exactly CLIP_HOLD cycles.
        begin
            int n;
            mix_in = 19'sd100000; mix_valid = 1'b1;
            exp_q.push_back(32'h7FFF_0000);
            @(negedge CLOCK_50);
            mix_valid = 1'b0;
            check("clip_before_s2", {31'd0, clip_led}, 32'd0);
            @(negedge CLOCK_50);
            n = 0;
            while (clip_led && n < CLIP_HOLD + 10) begin
                n++;
                @(negedge CLOCK_50);
            end
            check("clip_hold_cycles", n, CLIP_HOLD);
        end
        repeat (3) @(negedge CLOCK_50);

        // Overflow: six back-to-back strobes into a blocked codec.
        audio_out_allowed = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            mix_in = 19'(k); mix_valid = 1'b1;
            if (k <= 4) exp_q.push_back({16'(k), 16'h0000});
            @(negedge CLOCK_50);
        end
        mix_valid = 1'b0;
        repeat (6) @(negedge CLOCK_50);
        check("blocked_write", {31'd0, write_audio_out}, 32'd0);
        check("ovf_after_6", {24'd0, overflow_cnt}, 32'd2);
        audio_out_allowed = 1'b1;
        repeat (8) @(negedge CLOCK_50);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_write_low", {31'd0, write_audio_out}, 32'd0);

        // Full FIFO with push and pop on the same edge: nothing lost.
        audio_out_allowed = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mix_in = 19'(10 + k); mix_valid = 1'b1;
            exp_q.push_back({16'(10 + k), 16'h0000});
            @(negedge CLOCK_50);
        end
        mix_valid = 1'b0;
        @(negedge CLOCK_50);
        audio_out_allowed = 1'b1;
        @(negedge CLOCK_50);
        check("ovf_push_pop_full", {24'd0, overflow_cnt}, 32'd2);
        repeat (8) @(negedge CLOCK_50);
        check("pushpop_queue_empty", exp_q.size(), 0);

        // Reset mid-stream with three samples buffered and the clip LED lit.
        audio_out_allowed = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mix_in = (k == 0) ? 19'sd100000 : 19'(20 + k); mix_valid = 1'b1;
            @(negedge CLOCK_50);
        end
        mix_valid = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        check("pre_reset_clip", {31'd0, clip_led}, 32'd1);
        audio_out_allowed = 1'b1;
        #2 resetn = 1'b0;
        #1;
        check("midrst_write", {31'd0, write_audio_out}, 32'd0);
        check("midrst_left", left_audio_out, 32'd0);
        check("midrst_right", right_audio_out, 32'd0);
        check("midrst_clip", {31'd0, clip_led}, 32'd0);
        check("midrst_ovf", {24'd0, overflow_cnt}, 32'd0);
        exp_q.delete();
        @(negedge CLOCK_50);
        resetn = 1'b1;
        @(negedge CLOCK_50);
        check("post_rst_empty", {31'd0, write_audio_out}, 32'd0);
        latency_run(19'sd2000, 32'h07D0_0000);
        repeat (4) @(negedge CLOCK_50);

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
